// File: rtl/cpu_run_ctl.sv
// cpu_run_ctl: execution controller between the host stepping interface and
// the CPU core. Instead of toggling the core clock, it gates execution with a
// per-cycle enable. It supports HALT / STEP / RUN_N / RUN_FREE commands,
// instruction-pointer breakpoints, an IP-range fault stop and an
// executed-instruction counter.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   cmd_valid/ready   host command handshake (accepted when both high at posedge)
//   cmd_op            0 HALT, 1 STEP, 2 RUN_N, 3 RUN_FREE
//   cmd_count         instruction budget for RUN_N
//   bp_we/idx/addr/en breakpoint slot write port
//   ip                current instruction pointer from the core
//   core_en           core executes one instruction on a posedge where high
//   state             0 IDLE, 1 RUN, 2 FAULT
//   halt_cause        0 NONE, 1 HOST, 2 COUNT, 3 BREAK, 4 IP_RANGE
//   instr_count       executed instruction counter (wraps)
//   done              one-cycle pulse after a stop
module cpu_run_ctl #(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned IP_LIMIT  = 256,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned NUM_BP    = 4,
  localparam int unsigned IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  input  logic                 bp_we,
  input  logic [IDX_W-1:0]     bp_idx,
  input  logic [ADDR_SIZE-1:0] bp_addr,
  input  logic                 bp_en,
  input  logic [ADDR_SIZE-1:0] ip,
  output logic                 core_en,
  output logic [1:0]           state,
  output logic [2:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_HOST     = 3'd1,
    HC_COUNT    = 3'd2,
    HC_BREAK    = 3'd3,
    HC_IP_RANGE = 3'd4
  } cause_e;

  typedef enum logic [1:0] {
    OP_HALT     = 2'd0,
    OP_STEP     = 2'd1,
    OP_RUN_N    = 2'd2,
    OP_RUN_FREE = 2'd3
  } op_e;

  localparam logic [ADDR_SIZE-1:0] IP_LIM   = ADDR_SIZE'(IP_LIMIT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Control state
  state_e               state_q, state_d;
  cause_e               cause_q, cause_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 free_q, free_d;
  logic                 bp_skip_q, bp_skip_d;
  logic                 done_q, done_d;

  // Breakpoint slots
  logic [ADDR_SIZE-1:0] bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0]    bp_valid_q;

  logic bp_hit_c;
  logic ip_fault_c;
  logic cmd_accept_c;

  // Outside IDLE only HALT is accepted; other commands stall.
  assign cmd_ready    = (state_q == ST_IDLE) || (op_e'(cmd_op) == OP_HALT);
  assign cmd_accept_c = cmd_valid && cmd_ready;
  assign ip_fault_c   = (ip > IP_LIM);

  // Breakpoint compare against registered slots, so a same-cycle write
  // still sees the old contents.
  always_comb begin
    bp_hit_c = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == ip)) begin
        bp_hit_c = 1'b1;
      end
    end
  end

  // Breakpoint slot storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_valid_q <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= '0;
      end
    end else if (bp_we && (32'(bp_idx) < NUM_BP)) begin
      bp_addr_q[bp_idx]  <= bp_addr;
      bp_valid_q[bp_idx] <= bp_en;
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= HC_NONE;
      count_q     <= '0;
      remaining_q <= '0;
      free_q      <= 1'b0;
      bp_skip_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      free_q      <= free_d;
      bp_skip_q   <= bp_skip_d;
      done_q      <= done_d;
    end
  end

  // Next-state and core enable
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    free_d      = free_q;
    bp_skip_d   = bp_skip_q;
    done_d      = 1'b0;
    core_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_accept_c) begin
          unique case (op_e'(cmd_op))
            OP_HALT: begin
              cause_d = HC_HOST;
              done_d  = 1'b1;
            end
            OP_STEP: begin
              remaining_d = CNT_ONE;
              free_d      = 1'b0;
              bp_skip_d   = 1'b1;
              state_d     = ST_RUN;
            end
            OP_RUN_N: begin
              if (cmd_count == CNT_ZERO) begin
                cause_d = HC_COUNT;
                done_d  = 1'b1;
              end else begin
                remaining_d = cmd_count;
                free_d      = 1'b0;
                bp_skip_d   = 1'b1;
                state_d     = ST_RUN;
              end
            end
            OP_RUN_FREE: begin
              free_d    = 1'b1;
              bp_skip_d = 1'b1;
              state_d   = ST_RUN;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        // Stop conditions in priority order; the stopping instruction is
        // never executed.
        if (cmd_accept_c) begin
          state_d = ST_IDLE;
          cause_d = HC_HOST;
          done_d  = 1'b1;
        end else if (ip_fault_c) begin
          state_d = ST_FAULT;
          cause_d = HC_IP_RANGE;
          done_d  = 1'b1;
        end else if (bp_hit_c && !bp_skip_q) begin
          state_d = ST_IDLE;
          cause_d = HC_BREAK;
          done_d  = 1'b1;
        end else begin
          core_en   = 1'b1;
          count_d   = count_q + CNT_ONE;
          bp_skip_d = 1'b0;
          if (!free_q) begin
            remaining_d = remaining_q - CNT_ONE;
            // Last budgeted instruction executes on the same edge that stops.
            if (remaining_q == CNT_ONE) begin
              state_d = ST_IDLE;
              cause_d = HC_COUNT;
              done_d  = 1'b1;
            end
          end
        end
      end

      ST_FAULT: begin
        // Only HALT is ready here; cause keeps reporting the fault.
        if (cmd_accept_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state       = state_q;
  assign halt_cause  = cause_q;
  assign instr_count = count_q;
  assign done        = done_q;

endmodule
